fifo_sb_checker: RTL and testbench

//  Synthesizable scoreboard for the synchronous FIFO. Passively taps DUT inputs/outputs, runs an internal

---
 rtl/fifo_chk_pkg.sv | 39 +++
 rtl/fifo_ref_model.sv | 106 ++++++++++
 rtl/fifo_sb_checker.sv | 213 +++++++++++++++++++++
 tb/tb_fifo_sb_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO scoreboard: mis_mask bit positions,
// the packed flag bundle exchanged between reference model and checker,
// and the helper that builds a mismatch mask.
package fifo_chk_pkg;

  localparam int MIS_W      = 8;
  localparam int FLAG_W     = 7;

  localparam int MIS_DATA   = 0;
  localparam int MIS_FULL   = 1;
  localparam int MIS_EMPTY  = 2;
  localparam int MIS_AFULL  = 3;
  localparam int MIS_AEMPTY = 4;
  localparam int MIS_OVF    = 5;
  localparam int MIS_UDF    = 6;
  localparam int MIS_WRACK  = 7;

  // Member order is chosen so that {flags, data_bit} lines up with the
  // MIS_* positions above (first member is the MSB of a packed struct).
  typedef struct packed {
    logic wr_ack;
    logic underflow;
    logic overflow;
    logic almostempty;
    logic almostfull;
    logic empty;
    logic full;
  } fifo_flags_t;

  // One bit per differing output: flag bits in MIS_* order, data_out in bit 0.
  function automatic logic [MIS_W-1:0] build_mis_mask(input fifo_flags_t exp_f,
                                                      input fifo_flags_t act_f,
                                                      input logic        data_diff);
    logic [FLAG_W-1:0] flag_diff;
    flag_diff = exp_f ^ act_f;
    return {flag_diff, data_diff};
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Reference synchronous FIFO: the behavioural contract the tapped DUT is
// expected to follow. Registered data_out/wr_ack/overflow/underflow,
// combinational occupancy flags derived from the count.
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output fifo_flags_t       flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_ack_q, wr_ack_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full_s, empty_s;
  logic              wr_ok_s, rd_ok_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign wr_ok_s = wr_en & ~full_s;
  assign rd_ok_s = rd_en & ~empty_s;

  // Next state: pointers wrap naturally (DEPTH is a power of two), count tracks net change.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = wr_ok_s;
    ovf_d    = wr_en & full_s;
    udf_d    = rd_en & empty_s;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset; stored data is simply abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      dout_q   <= {DATA_W{1'b0}};
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: written only on an accepted write, no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out          = dout_q;
  assign flags.wr_ack      = wr_ack_q;
  assign flags.underflow   = udf_q;
  assign flags.overflow    = ovf_q;
  assign flags.almostempty = (count_q == CNT_W'(1));
  assign flags.almostfull  = (count_q == AFULL_C);
  assign flags.empty       = empty_s;
  assign flags.full        = full_s;

endmodule

// File: rtl/fifo_sb_checker.sv
// Passive scoreboard for the synchronous FIFO. Runs fifo_ref_model on the
// tapped DUT inputs, compares all eight DUT outputs each enabled cycle,
// keeps saturating pass/error counts, a sticky first-error snapshot and a
// sticky halt request.
// Optional build macro FIFO_CHK_COVER_EN adds saturating coverage counters
// (cov_full, cov_empty, cov_ovf, cov_udf, cov_wrrd).
module fifo_sb_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int CYC_W   = 32,
  parameter int MAX_ERR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_out,
  input  logic              full,
  input  logic              empty,
  input  logic              almostfull,
  input  logic              almostempty,
  input  logic              overflow,
  input  logic              underflow,
  input  logic              wr_ack,
  output logic              mismatch,
  output logic [MIS_W-1:0]  mis_mask,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  pass_count,
  output logic              first_vld,
  output logic [CYC_W-1:0]  first_cyc,
  output logic [MIS_W-1:0]  first_mask,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_act,
  output logic              halt_req
`ifdef FIFO_CHK_COVER_EN
  ,
  output logic [CNT_W-1:0]  cov_full,
  output logic [CNT_W-1:0]  cov_empty,
  output logic [CNT_W-1:0]  cov_ovf,
  output logic [CNT_W-1:0]  cov_udf,
  output logic [CNT_W-1:0]  cov_wrrd
`endif
);

  localparam bit               HALT_EN   = (MAX_ERR != 0);
  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

  // Increment unless already at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && !(&v)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  logic [DATA_W-1:0] exp_data_s;
  fifo_flags_t       exp_flags_s;
  fifo_flags_t       act_flags_s;
  logic [MIS_W-1:0]  mask_s;
  logic              fail_s;
  logic              cmp_fail_s;

  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  pass_count_q, pass_count_d;
  logic              mismatch_q, mismatch_d;
  logic [MIS_W-1:0]  mis_mask_q, mis_mask_d;
  logic              first_vld_q, first_vld_d;
  logic [CYC_W-1:0]  first_cyc_q, first_cyc_d;
  logic [MIS_W-1:0]  first_mask_q, first_mask_d;
  logic [DATA_W-1:0] first_exp_q, first_exp_d;
  logic [DATA_W-1:0] first_act_q, first_act_d;
  logic              halt_q, halt_d;

  fifo_ref_model #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_model (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (exp_data_s),
    .flags    (exp_flags_s)
  );

  assign act_flags_s = {wr_ack, underflow, overflow, almostempty, almostfull, empty, full};
  assign mask_s      = build_mis_mask(exp_flags_s, act_flags_s, data_out != exp_data_s);
  assign fail_s      = |mask_s;
  assign cmp_fail_s  = chk_en & fail_s;

  // Compare result, statistics, first-error capture and halt request.
  always_comb begin
    cyc_d        = cyc_q + CYC_W'(1);
    err_count_d  = sat_inc(err_count_q, cmp_fail_s);
    pass_count_d = sat_inc(pass_count_q, chk_en & ~fail_s);
    mismatch_d   = cmp_fail_s;
    first_vld_d  = first_vld_q;
    first_cyc_d  = first_cyc_q;
    first_mask_d = first_mask_q;
    first_exp_d  = first_exp_q;
    first_act_d  = first_act_q;
    halt_d       = halt_q;
    if (cmp_fail_s) begin
      mis_mask_d = mask_s;
    end else begin
      mis_mask_d = {MIS_W{1'b0}};
    end
    if (cmp_fail_s && !first_vld_q) begin
      first_vld_d  = 1'b1;
      first_cyc_d  = cyc_q;
      first_mask_d = mask_s;
      first_exp_d  = exp_data_s;
      first_act_d  = data_out;
    end else begin
      first_vld_d  = first_vld_q;
    end
    if (HALT_EN && (err_count_d >= MAX_ERR_C)) begin
      halt_d = 1'b1;
    end else begin
      halt_d = halt_q;
    end
  end

  // Statistics registers; synchronous active-low reset wipes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q        <= {CYC_W{1'b0}};
      err_count_q  <= {CNT_W{1'b0}};
      pass_count_q <= {CNT_W{1'b0}};
      mismatch_q   <= 1'b0;
      mis_mask_q   <= {MIS_W{1'b0}};
      first_vld_q  <= 1'b0;
      first_cyc_q  <= {CYC_W{1'b0}};
      first_mask_q <= {MIS_W{1'b0}};
      first_exp_q  <= {DATA_W{1'b0}};
      first_act_q  <= {DATA_W{1'b0}};
      halt_q       <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      err_count_q  <= err_count_d;
      pass_count_q <= pass_count_d;
      mismatch_q   <= mismatch_d;
      mis_mask_q   <= mis_mask_d;
      first_vld_q  <= first_vld_d;
      first_cyc_q  <= first_cyc_d;
      first_mask_q <= first_mask_d;
      first_exp_q  <= first_exp_d;
      first_act_q  <= first_act_d;
      halt_q       <= halt_d;
    end
  end

  assign mismatch   = mismatch_q;
  assign mis_mask   = mis_mask_q;
  assign err_count  = err_count_q;
  assign pass_count = pass_count_q;
  assign first_vld  = first_vld_q;
  assign first_cyc  = first_cyc_q;
  assign first_mask = first_mask_q;
  assign first_exp  = first_exp_q;
  assign first_act  = first_act_q;
  assign halt_req   = halt_q;

`ifdef FIFO_CHK_COVER_EN
  logic [CNT_W-1:0] cov_full_q, cov_full_d;
  logic [CNT_W-1:0] cov_empty_q, cov_empty_d;
  logic [CNT_W-1:0] cov_ovf_q, cov_ovf_d;
  logic [CNT_W-1:0] cov_udf_q, cov_udf_d;
  logic [CNT_W-1:0] cov_wrrd_q, cov_wrrd_d;

  // Coverage events sampled on model state of compared cycles; "neither full nor empty" means 0<count<DEPTH.
  always_comb begin
    cov_full_d  = sat_inc(cov_full_q,  chk_en & exp_flags_s.full);
    cov_empty_d = sat_inc(cov_empty_q, chk_en & exp_flags_s.empty);
    cov_ovf_d   = sat_inc(cov_ovf_q,   chk_en & exp_flags_s.overflow);
    cov_udf_d   = sat_inc(cov_udf_q,   chk_en & exp_flags_s.underflow);
    cov_wrrd_d  = sat_inc(cov_wrrd_q,  chk_en & wr_en & rd_en &
                                       ~exp_flags_s.full & ~exp_flags_s.empty);
  end

  // Coverage counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_full_q  <= {CNT_W{1'b0}};
      cov_empty_q <= {CNT_W{1'b0}};
      cov_ovf_q   <= {CNT_W{1'b0}};
      cov_udf_q   <= {CNT_W{1'b0}};
      cov_wrrd_q  <= {CNT_W{1'b0}};
    end else begin
      cov_full_q  <= cov_full_d;
      cov_empty_q <= cov_empty_d;
      cov_ovf_q   <= cov_ovf_d;
      cov_udf_q   <= cov_udf_d;
      cov_wrrd_q  <= cov_wrrd_d;
    end
  end

  assign cov_full  = cov_full_q;
  assign cov_empty = cov_empty_q;
  assign cov_ovf   = cov_ovf_q;
  assign cov_udf   = cov_udf_q;
  assign cov_wrrd  = cov_wrrd_q;
`endif

endmodule

// File: tb/tb_fifo_sb_checker.sv
// Directed bench for fifo_sb_checker. A queue-based FIFO stands in for the
// tapped DUT (with knobs for a stuck almostfull and a corrupted data word);
// the checker's outputs are compared against hand-computed values. Cycle
// numbers in comments count rising edges since the last reset release.
module tb_fifo_sb_checker;

  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int CW  = 16;
  localparam int YW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chk_en;
  logic [DW-1:0] data_in;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_out;
  logic          full, empty, almostfull, almostempty, overflow, underflow, wr_ack;
  logic          mismatch;
  logic [7:0]    mis_mask;
  logic [CW-1:0] err_count, pass_count;
  logic          first_vld;
  logic [YW-1:0] first_cyc;
  logic [7:0]    first_mask;
  logic [DW-1:0] first_exp, first_act;
  logic          halt_req;
`ifdef FIFO_CHK_COVER_EN
  logic [CW-1:0] cov_full, cov_empty, cov_ovf, cov_udf, cov_wrrd;
`endif

  // Stand-in DUT state
  logic [DW-1:0] q[$];
  logic [DW-1:0] dut_dout;
  logic          dut_wrack, dut_ovf, dut_udf;
  logic          stuck_af, corrupt5;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fifo_sb_checker #(
    .DATA_W(DW), .DEPTH(DEP), .CNT_W(CW), .CYC_W(YW), .MAX_ERR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .overflow(overflow), .underflow(underflow), .wr_ack(wr_ack),
    .mismatch(mismatch), .mis_mask(mis_mask), .err_count(err_count),
    .pass_count(pass_count), .first_vld(first_vld), .first_cyc(first_cyc),
    .first_mask(first_mask), .first_exp(first_exp), .first_act(first_act),
    .halt_req(halt_req)
`ifdef FIFO_CHK_COVER_EN
    , .cov_full(cov_full), .cov_empty(cov_empty), .cov_ovf(cov_ovf),
    .cov_udf(cov_udf), .cov_wrrd(cov_wrrd)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_outputs();
    full        = (q.size() == DEP);
    empty       = (q.size() == 0);
    almostfull  = (q.size() == DEP - 1) && !stuck_af;
    almostempty = (q.size() == 1);
    wr_ack      = dut_wrack;
    overflow    = dut_ovf;
    underflow   = dut_udf;
    data_out    = (corrupt5 && dut_dout == 16'h0005) ? 16'h0004 : dut_dout;
  endtask

  // One clock: drive at negedge, stand-in DUT updates at posedge, return at next negedge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    int sz;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    drive_outputs();
    @(posedge clk);
    sz = q.size();
    if (!rst_n) begin
      q.delete();
      dut_dout  = 16'h0000;
      dut_wrack = 1'b0;
      dut_ovf   = 1'b0;
      dut_udf   = 1'b0;
    end else begin
      dut_wrack = w && (sz != DEP);
      dut_ovf   = w && (sz == DEP);
      dut_udf   = r && (sz == 0);
      if (r && sz != 0) dut_dout = q.pop_front();
      if (w && sz != DEP) q.push_back(d);
    end
    @(negedge clk);
    drive_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; chk_en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 16'h0000;
    dut_dout = 16'h0000; dut_wrack = 1'b0; dut_ovf = 1'b0; dut_udf = 1'b0;
    stuck_af = 1'b0; corrupt5 = 1'b0;
    drive_outputs();
    @(negedge clk);
    cycle(1'b0, 1'b0, 16'h0000);
    do_reset();
    check_vec("rst_err",   32'(err_count),  32'd0);
    check_vec("rst_pass",  32'(pass_count), 32'd0);
    check_vec("rst_mis",   32'(mismatch),   32'd0);
    check_vec("rst_fvld",  32'(first_vld),  32'd0);
    check_vec("rst_halt",  32'(halt_req),   32'd0);

    // A: 8 writes (cycles 0..7), 8 reads (8..15), read at empty (16), idle (17)
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 16'(i));
    check_vec("fill_pass", 32'(pass_count), 32'd8);
    check_vec("fill_full", 32'(full),       32'd1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      check_vec("drain_err", 32'(err_count), 32'd0);
    end
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("udf_err",  32'(err_count),  32'd0);
    check_vec("udf_pass", 32'(pass_count), 32'd18);
    check_vec("udf_mis",  32'(mismatch),   32'd0);

    // B: fill (18..25), write at full (26), idle (27)
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(16'h0011 + i));
    cycle(1'b1, 1'b0, 16'h00FF);
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("ovf_err",  32'(err_count),  32'd0);
    check_vec("ovf_pass", 32'(pass_count), 32'd28);
    check_vec("ovf_mis",  32'(mismatch),   32'd0);
    check_vec("ovf_mask", 32'(mis_mask),   32'd0);

    // C: drain to 4 (28..31), 20 simultaneous wr/rd (32..51)
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 16'(16'h0100 + i));
    check_vec("wrrd_err",  32'(err_count),  32'd0);
    check_vec("wrrd_pass", 32'(pass_count), 32'd52);
    check_vec("wrrd_fvld", 32'(first_vld),  32'd0);
    check_vec("wrrd_halt", 32'(halt_req),   32'd0);
`ifdef FIFO_CHK_COVER_EN
    check_vec("cov_wrrd",  32'(cov_wrrd),  32'd20);
    check_vec("cov_full",  32'(cov_full),  32'd4);
    check_vec("cov_empty", 32'(cov_empty), 32'd4);
    check_vec("cov_ovf",   32'(cov_ovf),   32'd1);
    check_vec("cov_udf",   32'(cov_udf),   32'd1);
`endif

    // D: count to 5 (52), reset mid-operation, then fresh traffic (0..3)
    cycle(1'b1, 1'b0, 16'h0200);
    do_reset();
    check_vec("mrst_err",  32'(err_count),  32'd0);
    check_vec("mrst_pass", 32'(pass_count), 32'd0);
    check_vec("mrst_fvld", 32'(first_vld),  32'd0);
    cycle(1'b1, 1'b0, 16'h00A1);
    cycle(1'b1, 1'b0, 16'h00A2);
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("post_err",  32'(err_count),  32'd0);
    check_vec("post_pass", 32'(pass_count), 32'd4);

    // E: idle 0..29, writes 30..36 (count 7), almostfull stuck-0 from cycle 37
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'(16'h0300 + i));
    check_vec("pre_af_err", 32'(err_count), 32'd0);
    stuck_af = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("af_mis",   32'(mismatch),   32'd1);
    check_vec("af_mask",  32'(mis_mask),   32'h08);
    check_vec("af_err",   32'(err_count),  32'd1);
    check_vec("af_pass",  32'(pass_count), 32'd37);
    check_vec("af_fvld",  32'(first_vld),  32'd1);
    check_vec("af_fcyc",  32'(first_cyc),  32'd37);
    check_vec("af_fmask", 32'(first_mask), 32'h08);
    check_vec("af_halt",  32'(halt_req),   32'd1);
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("af2_err",  32'(err_count),  32'd2);
    check_vec("af2_fcyc", 32'(first_cyc),  32'd37);
    stuck_af = 1'b0;
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("af3_mis",  32'(mismatch),   32'd0);
    check_vec("af3_mask", 32'(mis_mask),   32'd0);
    check_vec("af3_pass", 32'(pass_count), 32'd38);
    check_vec("af3_halt", 32'(halt_req),   32'd1);
    stuck_af = 1'b1;
    chk_en   = 1'b0;
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("dis_mis",  32'(mismatch),   32'd0);
    check_vec("dis_err",  32'(err_count),  32'd2);
    check_vec("dis_pass", 32'(pass_count), 32'd38);
    stuck_af = 1'b0;
    chk_en   = 1'b1;

    // F: write 1..5 (0..4), read 5 (5..9); 0x0005 shows up as 0x0004, compared at 10
    do_reset();
    check_vec("f_rst_fvld", 32'(first_vld), 32'd0);
    check_vec("f_rst_halt", 32'(halt_req),  32'd0);
    corrupt5 = 1'b1;
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0000);
    check_vec("pre_d_err", 32'(err_count), 32'd0);
    cycle(1'b0, 1'b0, 16'h0000);
    check_vec("d_mis",   32'(mismatch),   32'd1);
    check_vec("d_mask",  32'(mis_mask),   32'h01);
    check_vec("d_fmask", 32'(first_mask), 32'h01);
    check_vec("d_fexp",  32'(first_exp),  32'h0005);
    check_vec("d_fact",  32'(first_act),  32'h0004);
    check_vec("d_fcyc",  32'(first_cyc),  32'd10);
    check_vec("d_err",   32'(err_count),  32'd1);
    check_vec("d_halt",  32'(halt_req),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
